ncl_sum_sink: RTL and testbench

NCL_SUM_SINK -- requirements
Module: ncl_sum_sink

---
 rtl/ncl_sum_sink.sv | 116 +++++++++++
 tb/tb_ncl_sum_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_sum_sink.sv
// Completion sink for a dual-rail NCL ripple adder: synchronizes the sum and carry rails,
// detects DATA and NULL wavefronts, and queues each decoded result in a small FIFO.
module ncl_sum_sink #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         init_n,
  input  logic [N-1:0] sum0,
  input  logic [N-1:0] sum1,
  input  logic         cout0,
  input  logic         cout1,
  output logic         sumCOMP,
  output logic [N:0]   rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic         err,
  input  logic         err_clr,
  output logic [1:0]   o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    WAIT_NULL = 2'd1,
    STALL     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Rails packed as {carry, sum}, so bit N is the carry pair.
  logic [N:0] r_meta0, r_meta1, r_sync0, r_sync1;

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_meta0 <= '0;
      r_meta1 <= '0;
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_meta0 <= {cout0, sum0};
      r_meta1 <= {cout1, sum1};
      r_sync0 <= r_meta0;
      r_sync1 <= r_meta1;
    end
  end

  logic w_illegal, w_complete, w_all_null;
  assign w_illegal  = |(r_sync0 & r_sync1);
  assign w_complete = &(r_sync0 ^ r_sync1);
  assign w_all_null = ~|(r_sync0 | r_sync1);

  logic [AW:0] r_wptr, r_rptr;
  logic [N:0]  r_mem [DEPTH];
  logic        w_fifo_empty, w_fifo_full, w_push, w_pop, w_can_free;

  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_fifo_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop        = !w_fifo_empty && rd_ready;
  assign w_can_free   = !w_fifo_full || w_pop;

  // A capture only happens in WAIT_DATA, which is entered only with a free entry,
  // so the FIFO never sees a push while full.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_complete && !w_illegal) begin
          w_push = 1'b1;
          w_next = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (w_all_null) w_next = w_can_free ? WAIT_DATA : STALL;
      end
      STALL: begin
        if (w_can_free) w_next = WAIT_DATA;
      end
      default: w_next = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state <= WAIT_DATA;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_sync1;
  end

  logic r_err;
  always_ff @(posedge clk) begin
    if (!init_n)        r_err <= 1'b0;
    else if (w_illegal) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign sumCOMP     = (r_state != WAIT_DATA);
  assign rd_data     = r_mem[r_rptr[AW-1:0]];
  assign rd_valid    = !w_fifo_empty;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ncl_sum_sink.sv
// Directed bench for ncl_sum_sink: expected results are queued as wavefronts are issued
// and a monitor compares every popped FIFO word against the queue head.
module tb_ncl_sum_sink;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic         clk = 1'b0;
  logic         init_n;
  logic [N-1:0] sum0, sum1;
  logic         cout0, cout1;
  logic         sum_comp;
  logic [N:0]   rd_data;
  logic         rd_valid, rd_ready;
  logic         err, err_clr;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [N:0] exp_q[$];

  ncl_sum_sink #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .init_n(init_n), .sum0(sum0), .sum1(sum1), .cout0(cout0), .cout1(cout1),
    .sumCOMP(sum_comp), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .err(err), .err_clr(err_clr), .o_dbg_state(dbg_state)
  );

  // Clock: rising edges at 5, 15, ...; inputs change and checks happen on falling edges.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_data(input logic [N-1:0] val, input logic c);
    sum1 = val; sum0 = ~val; cout1 = c; cout0 = ~c;
  endtask

  task automatic drive_null();
    sum0 = '0; sum1 = '0; cout0 = 1'b0; cout1 = 1'b0;
  endtask

  task automatic wait_comp(input logic lvl, input int budget, input string name);
    int n = 0;
    while (sum_comp !== lvl && n < budget) begin
      step();
      n++;
    end
    check(name, {{N{1'b0}}, sum_comp}, {{N{1'b0}}, lvl});
  endtask

  // Monitor: looks 1 time unit before each rising edge, where a pop is about to happen.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (init_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got 0x%0h expected none", rd_data);
        end else begin
          check("pop_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    init_n = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
    drive_null();
    @(negedge clk);
    repeat (3) step();
    check("rst_rd_valid", {{N{1'b0}}, rd_valid}, '0);
    check("rst_sumcomp",  {{N{1'b0}}, sum_comp}, '0);
    check("rst_err",      {{N{1'b0}}, err}, '0);
    init_n = 1'b1;
    step();

    // Single wavefront 0xA5 with carry 1: exact edge timing.
    rd_ready = 1'b1;
    drive_data(8'hA5, 1'b1);
    exp_q.push_back(9'h1A5);
    step(); check("t1_comp_e1", {{N{1'b0}}, sum_comp}, '0);
    step(); check("t1_comp_e2", {{N{1'b0}}, sum_comp}, '0);
    step(); check("t1_comp_e3", {{N{1'b0}}, sum_comp}, 9'd1);
    check("t1_valid_e3", {{N{1'b0}}, rd_valid}, 9'd1);
    drive_null();
    step(); check("t1_valid_e4", {{N{1'b0}}, rd_valid}, '0);
    check("t1_comp_n1", {{N{1'b0}}, sum_comp}, 9'd1);
    step(); check("t1_comp_n2", {{N{1'b0}}, sum_comp}, 9'd1);
    step(); check("t1_comp_n3", {{N{1'b0}}, sum_comp}, '0);

    // Digits arrive one per cycle; carry last.
    for (int i = 0; i < N; i++) begin
      logic [7:0] v;
      v = 8'h3C;
      sum1[i] = v[i];
      sum0[i] = ~v[i];
      step();
      check("t2_partial_comp", {{N{1'b0}}, sum_comp}, '0);
    end
    step();
    step();
    check("t2_no_push", {{N{1'b0}}, rd_valid}, '0);
    exp_q.push_back(9'h03C);
    cout0 = 1'b1;
    wait_comp(1'b1, 6, "t2_capture");
    drive_null();
    wait_comp(1'b0, 6, "t2_release");

    // Backpressure: five wavefronts into a four-entry FIFO.
    rd_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      drive_data(8'(v), 1'b0);
      exp_q.push_back(9'(v));
      wait_comp(1'b1, 8, "t3_capture");
      drive_null();
      if (v < 4) wait_comp(1'b0, 8, "t3_release");
    end
    repeat (6) step();
    check("t3_stall_comp",  {{N{1'b0}}, sum_comp}, 9'd1);
    check("t3_stall_state", {7'd0, dbg_state}, {7'd0, ST_STALL});
    drive_data(8'h05, 1'b0);
    exp_q.push_back(9'h005);
    repeat (4) step();
    check("t3_no_capture", {{N{1'b0}}, sum_comp}, 9'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t3_freed_comp", {{N{1'b0}}, sum_comp}, '0);
    step();
    check("t3_fifth_comp", {{N{1'b0}}, sum_comp}, 9'd1);
    drive_null();
    repeat (4) step();
    check("t3_full_stall", {7'd0, dbg_state}, {7'd0, ST_STALL});

    // Pop one to leave STALL, then pop exactly on the next capture edge.
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    drive_data(8'h06, 1'b0);
    exp_q.push_back(9'h006);
    step();
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t4_capture_with_pop", {{N{1'b0}}, sum_comp}, 9'd1);
    check("t4_still_valid", {{N{1'b0}}, rd_valid}, 9'd1);
    drive_null();
    rd_ready = 1'b1;
    repeat (6) step();
    check("t4_drained", {{N{1'b0}}, rd_valid}, '0);
    check("t4_sumcomp_low", {{N{1'b0}}, sum_comp}, '0);

    // Illegal code on digit 3.
    drive_data(8'h0F, 1'b1);
    sum0[3] = 1'b1;
    step(); step();
    check("t5_err_pre", {{N{1'b0}}, err}, '0);
    step();
    check("t5_err_set", {{N{1'b0}}, err}, 9'd1);
    repeat (3) step();
    check("t5_no_capture", {{N{1'b0}}, sum_comp}, '0);
    check("t5_no_push", {{N{1'b0}}, rd_valid}, '0);
    drive_null();
    repeat (3) step();
    check("t5_err_sticky", {{N{1'b0}}, err}, 9'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_clr", {{N{1'b0}}, err}, '0);
    drive_data(8'h77, 1'b1);
    exp_q.push_back(9'h177);
    wait_comp(1'b1, 8, "t5_after_err");
    drive_null();
    wait_comp(1'b0, 8, "t5_release");

    // Reset with two entries queued and sumCOMP high.
    rd_ready = 1'b0;
    drive_data(8'h11, 1'b0);
    wait_comp(1'b1, 8, "t6_cap1");
    drive_null();
    wait_comp(1'b0, 8, "t6_rel1");
    drive_data(8'h22, 1'b0);
    wait_comp(1'b1, 8, "t6_cap2");
    init_n = 1'b0;
    step();
    check("t6_rst_valid", {{N{1'b0}}, rd_valid}, '0);
    check("t6_rst_comp",  {{N{1'b0}}, sum_comp}, '0);
    check("t6_rst_err",   {{N{1'b0}}, err}, '0);
    init_n = 1'b1;
    exp_q.push_back(9'h022);
    rd_ready = 1'b1;
    wait_comp(1'b1, 8, "t6_recapture");
    drive_null();
    wait_comp(1'b0, 8, "t6_release");
    repeat (3) step();
    check("final_queue_empty", 9'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
